fop_axis: RTL

FOP_AXIS -- requirements
Module: fop_axis

---
 rtl/fop_axis.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fop_axis.sv
// Floating-point add/sub front end: issues operands to an AXI-Stream FP core and collects in-order results.
// Optional watchdog (sticky err on stalled results) is compiled in with `define FOP_AXIS_WATCHDOG_EN.
module fop_axis #(
    parameter int W       = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic         op,
    input  logic [W-1:0] adata,
    input  logic [W-1:0] bdata,
    output logic         accept,
    output logic         full,
    output logic         busy,
    output logic [W-1:0] result,
    output logic         done,
    output logic [3:0]   pending,
    output logic [W-1:0] a_tdata,
    output logic         a_tvalid,
    input  logic         a_tready,
    output logic [W-1:0] b_tdata,
    output logic         b_tvalid,
    input  logic         b_tready,
    input  logic [W-1:0] r_tdata,
    input  logic         r_tvalid,
    output logic         r_tready
`ifdef FOP_AXIS_WATCHDOG_EN
    ,
    output logic         err
`endif
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t     state, state_nx;
    logic       take, a_hs, b_hs, r_hs;
    logic       a_tvalid_nx, b_tvalid_nx;
    logic [3:0] pending_nx;

    assign full = (state == ISSUE) || (pending == 4'(DEPTH));
    assign busy = (state == ISSUE) || (pending != 4'd0);
    assign take = en && !full;
    assign a_hs = a_tvalid && a_tready;
    assign b_hs = b_tvalid && b_tready;
    // r_tready is only ever high with pending>0, so stray results are never handshaken
    assign r_hs = r_tvalid && r_tready;

    always_comb begin
        state_nx    = state;
        a_tvalid_nx = a_tvalid;
        b_tvalid_nx = b_tvalid;
        case (state)
            IDLE: begin
                if (take) begin
                    state_nx    = ISSUE;
                    a_tvalid_nx = 1'b1;
                    b_tvalid_nx = 1'b1;
                end
            end
            ISSUE: begin
                if (a_hs) a_tvalid_nx = 1'b0;
                if (b_hs) b_tvalid_nx = 1'b0;
                if (!a_tvalid_nx && !b_tvalid_nx) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pending_nx = pending;
        case ({take, r_hs})
            2'b10:   pending_nx = pending + 4'd1;
            2'b01:   pending_nx = pending - 4'd1;
            default: pending_nx = pending;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            a_tvalid <= 1'b0;
            b_tvalid <= 1'b0;
            a_tdata  <= '0;
            b_tdata  <= '0;
            accept   <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            pending  <= 4'd0;
            r_tready <= 1'b0;
        end else begin
            state    <= state_nx;
            a_tvalid <= a_tvalid_nx;
            b_tvalid <= b_tvalid_nx;
            accept   <= take;
            done     <= r_hs;
            pending  <= pending_nx;
            r_tready <= (pending_nx != 4'd0);
            if (take) begin
                a_tdata <= adata;
                // subtraction is addition with b's sign bit inverted, whatever b encodes
                b_tdata <= {bdata[W-1] ^ op, bdata[W-2:0]};
            end
            if (r_hs) result <= r_tdata;
        end
    end

`ifdef FOP_AXIS_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (r_hs || (pending == 4'd0)) begin
                wd_cnt <= '0;
            end else if (wd_cnt != CW'(TIMEOUT)) begin
                wd_cnt <= wd_cnt + CW'(1);
            end
            if (wd_cnt == CW'(TIMEOUT)) err <= 1'b1;
        end
    end
`endif

endmodule
